posit_add_arbiter_es3: RTL and testbench
========================================

Name: posit_add_arbiter_es3

Overview:
- Shares one pipelined raw ES3 posit adder between NREQ requesters.
- Round-robin issue at up to one operation per cycle.
- Tags every in-flight operation and routes each raw sum back to its owner through a per-requester response FIFO.
- Credit-based issue guarantees no FIFO overflow. The adder has no stall input, so nothing in flight may be dropped.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 8, cycles from adder start to adder done.
- DEPTH, 4, entries per response FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  operand pair offered by requester i.
- req_ready  out  NREQ  grant; handshake when valid&ready.
- req_in1  in  NREQ*POSIT_SERIALIZED_WIDTH_ES3  serialized operand A; slice i belongs to requester i.
- req_in2  in  NREQ*POSIT_SERIALIZED_WIDTH_ES3  serialized operand B.
- rsp_valid  out  NREQ  FIFO i non-empty.
- rsp_ready  in  NREQ  pop FIFO i when valid&ready.
- rsp_sum  out  NREQ*POSIT_SERIALIZED_WIDTH_SUM_ES3  head of FIFO i.
- add_in1, add_in2  out  POSIT_SERIALIZED_WIDTH_ES3  registered operands to the adder.
- add_start  out  1  registered issue strobe.
- add_result  in  POSIT_SERIALIZED_WIDTH_SUM_ES3  adder sum.
- add_done  in  1  adder completion strobe.
- err  out  1  sticky protocol error.

Behaviour:
- **Reset values:** req_ready=0, rsp_valid=0, add_start=0, add_in1/add_in2=0, err=0. All credits=DEPTH, FIFOs empty, tag pipeline cleared, RR pointer=NREQ-1, blank counter=LATENCY.
- **Eligibility:** elig[i] = req_valid[i] & (credit[i]!=0). Credit is read from the register, so a pop in the same cycle does not make a credit-0 requester eligible.
- **Grant:** combinational one-hot. Pick the first eligible index scanning from ptr+1 upward, with wrap. req_ready=grant; req_ready never asserts without req_valid.
- **Pointer:** ptr<=granted index on any grant; unchanged when there is no grant.
- **Issue register:** on a grant, next cycle add_start=1 and add_in1/add_in2 = the granted slices; otherwise add_start=0 and the operands hold.
- **Tag pipeline:** LATENCY stages of {valid, idx}. Stage 0 is loaded with {add_start, idx of issued op}. The last stage aligns with add_done.
- **Latency:** handshake in cycle k, add_start in k+1, add_done in k+1+LATENCY, write into FIFO idx at that edge, rsp_valid[idx] in k+2+LATENCY (10 cycles at default).
- **Credits:** grant → credit-1; pop → credit+1; both in the same cycle → unchanged. Width $clog2(DEPTH+1). Invariant: occupancy+inflight+credit = DEPTH.
- **Ordering:** FIFO writes are in issue order, so each requester sees results in request order.
- **Simultaneous events:** a write to FIFO i and a pop from FIFO i in the same cycle are both performed.
  - Empty FIFO with write and rsp_ready: no bypass; data appears next cycle.
  - Full FIFO with write: cannot occur under credits. If it does, set err and drop the write.
- **Blank window:** counts down from LATENCY after reset. While nonzero, add_done with an invalid tag is ignored silently; these are stale ops from the un-resettable adder pipeline.
- **err:** after the blank window, set when add_done != last-stage valid. A tag with no done drops the tag and restores that requester's credit. A done with no tag is discarded. err stays set until rst.
- **Reset mid-operation:** all in-flight results are discarded; requesters must re-issue. New issues are legal from the first cycle after reset.
- **Scope:** no arithmetic is performed on posit fields; payloads pass through bit-exact.

Decomposition:
- Package posit_defines_es3 supplies POSIT_SERIALIZED_WIDTH_ES3 and POSIT_SERIALIZED_WIDTH_SUM_ES3.
- Add to the package: typedef arb_tag_t {logic valid; logic [2:0] idx;}, and a function rr_pick(elig, ptr) returning one-hot.
- One sub-module: posit_sum_fifo, a synchronous FIFO parameterized by DEPTH.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full.
  - Instantiated NREQ times.
- The adder itself is instantiated by the parent, not inside this block.

Test Plan:
- **Single op:** requester 0 sends 1.0+1.0 (sgn 0, scale 0, fraction 0, inf 0, zero 0) in cycle 5. Expect add_start in cycle 6, rsp_valid[0] in cycle 15, rsp_sum equal to the adder model (sgn 0, scale 1), err=0.
- **Full contention:** all 4 requesters hold valid for 12 cycles with rsp_ready=1. Expect grants 0,1,2,3,0,1,… one per cycle, add_start high for 12 consecutive cycles, 3 results per requester in order.
- **Backpressure:** rsp_ready[2]=0 with DEPTH=4 and requester 2 always valid. Expect exactly 4 grants to 2, then req_ready[2]=0 while 0,1,3 continue. Raising rsp_ready[2] pops 4 results in order and grants to 2 resume one cycle after the first pop.
- **Credit-0 pop:** credit[1]=0 and a pop of FIFO 1 in cycle t. Expect no grant to 1 in cycle t; grant in cycle t+1.
- **Reset mid-flight:** 3 ops in flight, rst high for 1 cycle. Expect all rsp_valid=0 and stale add_done pulses ignored with err=0. A new op issued right after reset returns correctly after 10 cycles.
- **Spurious done:** add_done pulsed 20 cycles after reset with no op outstanding. Expect err=1 next cycle and still 1 ten cycles later; no FIFO written.

Source files
------------

// File: rtl/posit_add_arbiter_es3_pkg.sv
// Shared widths, tag type and round-robin helper for the ES3 posit adder arbiter.
package posit_defines_es3;

  localparam int POSIT_SCALE_WIDTH_ES3         = 8;
  localparam int POSIT_FRAC_WIDTH_ES3          = 8;
  // {sgn, scale, fraction, inf, zero}
  localparam int POSIT_SERIALIZED_WIDTH_ES3    = 1 + POSIT_SCALE_WIDTH_ES3 + POSIT_FRAC_WIDTH_ES3 + 2;
  localparam int POSIT_SCALE_WIDTH_SUM_ES3     = POSIT_SCALE_WIDTH_ES3 + 1;
  localparam int POSIT_FRAC_WIDTH_SUM_ES3      = POSIT_FRAC_WIDTH_ES3 + 2;
  localparam int POSIT_SERIALIZED_WIDTH_SUM_ES3 = 1 + POSIT_SCALE_WIDTH_SUM_ES3 + POSIT_FRAC_WIDTH_SUM_ES3 + 2;

  localparam int ARB_MAX_NREQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } arb_tag_t;

  // One-hot pick of the first eligible index after ptr, wrapping at nreq.
  function automatic logic [ARB_MAX_NREQ-1:0] rr_pick(
    input logic [ARB_MAX_NREQ-1:0] elig,
    input logic [2:0]              ptr,
    input int                      nreq
  );
    logic [ARB_MAX_NREQ-1:0] pick;
    logic                    found;
    logic [2:0]              idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= ARB_MAX_NREQ; off++) begin
      if (off <= nreq) begin
        idx = 3'((int'(ptr) + off) % nreq);
        if (!found && elig[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/posit_add_arbiter_es3_if.sv
// Requester, response and adder-side signals of the shared posit adder arbiter.
interface posit_add_arbiter_es3_if
  import posit_defines_es3::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]                                req_valid;
  logic [NREQ-1:0]                                req_ready;
  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]     req_in1;
  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]     req_in2;
  logic [NREQ-1:0]                                rsp_valid;
  logic [NREQ-1:0]                                rsp_ready;
  logic [NREQ*POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] rsp_sum;
  logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]          add_in1;
  logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]          add_in2;
  logic                                           add_start;
  logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0]      add_result;
  logic                                           add_done;
  logic                                           err;

  modport slave (
    input  req_valid, req_in1, req_in2, rsp_ready, add_result, add_done,
    output req_ready, rsp_valid, rsp_sum, add_in1, add_in2, add_start, err
  );

  modport master (
    output req_valid, req_in1, req_in2, rsp_ready, add_result, add_done,
    input  req_ready, rsp_valid, rsp_sum, add_in1, add_in2, add_start, err
  );
endinterface

// File: rtl/posit_add_arbiter_es3_fifo.sv
// Synchronous show-ahead FIFO holding raw sums for one requester.
module posit_sum_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is dropped; the parent flags it.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(do_wr) - CW'(do_rd);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
endmodule

// File: rtl/posit_add_arbiter_es3.sv
// Round-robin, credit-gated sharing of one pipelined raw ES3 posit adder among NREQ requesters.
module posit_add_arbiter_es3
  import posit_defines_es3::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 8,
  parameter int DEPTH   = 4
) (
  input logic                    clk,
  input logic                    rst,
  posit_add_arbiter_es3_if.slave bus
);
  localparam int AW = POSIT_SERIALIZED_WIDTH_ES3;
  localparam int SW = POSIT_SERIALIZED_WIDTH_SUM_ES3;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(LATENCY + 1);

  logic [NREQ-1:0]         elig;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         fifo_wr;
  logic [NREQ-1:0]         fifo_rd;
  logic [NREQ-1:0]         fifo_empty;
  logic [NREQ-1:0]         fifo_full;
  logic [NREQ-1:0]         restore;
  logic [ARB_MAX_NREQ-1:0] elig_wide;
  logic [ARB_MAX_NREQ-1:0] pick;
  logic [2:0]              grant_idx;
  logic                    any_grant;
  logic [AW-1:0]           op1_next;
  logic [AW-1:0]           op2_next;
  logic [SW-1:0]           fifo_data [NREQ];
  logic [CW-1:0]           credit_reg [NREQ];
  logic [2:0]              ptr_reg;
  logic [2:0]              issue_idx_reg;
  logic                    start_reg;
  logic [AW-1:0]           in1_reg;
  logic [AW-1:0]           in2_reg;
  arb_tag_t                tag_reg [LATENCY];
  arb_tag_t                tag_last;
  logic [BW-1:0]           blank_reg;
  logic                    err_reg;
  logic                    done_hit;
  logic                    tag_lost;
  logic                    overflow;

  always_comb begin
    elig_wide            = '0;
    elig_wide[NREQ-1:0]  = elig;
    pick                 = rr_pick(elig_wide, ptr_reg, NREQ);
    grant                = pick[NREQ-1:0];
    any_grant            = |grant;
    grant_idx            = '0;
    op1_next             = '0;
    op2_next             = '0;
    for (int i = 0; i < ARB_MAX_NREQ; i++) begin
      if (pick[i]) grant_idx = 3'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op1_next = bus.req_in1[i*AW +: AW];
        op2_next = bus.req_in2[i*AW +: AW];
      end
    end
  end

  assign tag_last = tag_reg[LATENCY-1];
  assign done_hit = bus.add_done & tag_last.valid;
  assign tag_lost = tag_last.valid & ~bus.add_done;
  assign overflow = |(fifo_wr & fifo_full);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      // Credit comes from the register, so a same-cycle pop cannot unblock a grant.
      assign elig[gi]    = ~rst & bus.req_valid[gi] & (credit_reg[gi] != '0);
      assign fifo_wr[gi] = done_hit & (tag_last.idx == 3'(gi));
      assign restore[gi] = tag_lost & (tag_last.idx == 3'(gi));
      assign fifo_rd[gi] = bus.rsp_ready[gi] & ~fifo_empty[gi];

      posit_sum_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SW)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr[gi]),
        .wr_data (bus.add_result),
        .rd_en   (fifo_rd[gi]),
        .rd_data (fifo_data[gi]),
        .empty   (fifo_empty[gi]),
        .full    (fifo_full[gi])
      );

      assign bus.rsp_valid[gi]         = ~fifo_empty[gi];
      assign bus.rsp_sum[gi*SW +: SW]  = fifo_data[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) begin
        credit_reg[i] <= CW'(DEPTH);
      end else begin
        credit_reg[i] <= credit_reg[i] - CW'(grant[i]) + CW'(fifo_rd[i]) + CW'(restore[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= 3'(NREQ - 1);
      start_reg     <= 1'b0;
      issue_idx_reg <= '0;
      in1_reg       <= '0;
      in2_reg       <= '0;
    end else begin
      start_reg <= any_grant;
      if (any_grant) begin
        ptr_reg       <= grant_idx;
        issue_idx_reg <= grant_idx;
        in1_reg       <= op1_next;
        in2_reg       <= op2_next;
      end
    end
  end

  // Tag shift register mirrors the adder pipeline; its last stage lines up with add_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LATENCY; j++) tag_reg[j] <= '0;
    end else begin
      for (int j = LATENCY - 1; j > 0; j--) tag_reg[j] <= tag_reg[j-1];
      tag_reg[0] <= '{valid: start_reg, idx: issue_idx_reg};
    end
  end

  // The adder is not reset, so stale completions may surface for LATENCY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_reg <= BW'(LATENCY);
      err_reg   <= 1'b0;
    end else begin
      if (blank_reg != '0) blank_reg <= blank_reg - 1'b1;
      if (((blank_reg == '0) && (bus.add_done != tag_last.valid)) || overflow) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.add_start = start_reg;
  assign bus.add_in1   = in1_reg;
  assign bus.add_in2   = in2_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_posit_add_arbiter_es3.sv
// Directed and randomized checks of the posit adder arbiter against a scoreboard and adder model.
module tb_posit_add_arbiter_es3;
  import posit_defines_es3::*;

  localparam int NREQ = 4;
  localparam int LAT  = 8;
  localparam int DEP  = 4;
  localparam int AW   = POSIT_SERIALIZED_WIDTH_ES3;
  localparam int SW   = POSIT_SERIALIZED_WIDTH_SUM_ES3;

  logic clk = 1'b0;
  logic rst;
  logic spurious = 1'b0;
  logic [LAT-1:0] pipe_v = '0;
  logic [SW-1:0]  pipe_d [LAT];

  int n_checks = 0;
  int n_errors = 0;
  logic [SW-1:0] exp_q [NREQ][$];
  int grant_log [$];
  int pop_cnt [NREQ];

  posit_add_arbiter_es3_if #(.NREQ(NREQ)) bus ();

  posit_add_arbiter_es3 #(
    .NREQ    (NREQ),
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Raw sum: align on scale, add signed magnitudes, renormalize, truncate fraction.
  function automatic logic [SW-1:0] raw_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic sa, sb, s, ts;
    int ea, eb, e, d, p, te;
    logic [31:0] ma, mb, m, t, tm;
    sa = a[18]; ea = int'($signed(a[17:10])); ma = {23'd0, 1'b1, a[9:2]} << 20;
    sb = b[18]; eb = int'($signed(b[17:10])); mb = {23'd0, 1'b1, b[9:2]} << 20;
    if (a[1] || b[1]) return {1'b0, 9'd0, 10'd0, 1'b1, 1'b0};
    if (a[0] && b[0]) return {1'b0, 9'd0, 10'd0, 1'b0, 1'b1};
    if (a[0]) return {sb, 9'(eb), b[9:2], 2'b00, 2'b00};
    if (b[0]) return {sa, 9'(ea), a[9:2], 2'b00, 2'b00};
    if (ea < eb) begin
      ts = sa; sa = sb; sb = ts;
      te = ea; ea = eb; eb = te;
      tm = ma; ma = mb; mb = tm;
    end
    d = ea - eb;
    if (d > 31) d = 31;
    mb = mb >> d;
    e  = ea;
    if (sa == sb) begin m = ma + mb; s = sa; end
    else if (ma >= mb) begin m = ma - mb; s = sa; end
    else begin m = mb - ma; s = sb; end
    if (m == 0) return {1'b0, 9'd0, 10'd0, 1'b0, 1'b1};
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    t = m << (31 - p);
    return {s, 9'(e + p - 28), t[30:21], 2'b00};
  endfunction

  // Behavioural adder: fixed latency, no reset, no stall.
  always @(posedge clk) begin
    pipe_v <= {pipe_v[LAT-2:0], bus.add_start};
    pipe_d[0] <= raw_add(bus.add_in1, bus.add_in2);
    for (int j = 1; j < LAT; j++) pipe_d[j] <= pipe_d[j-1];
  end
  assign bus.add_done   = pipe_v[LAT-1] | spurious;
  assign bus.add_result = pipe_d[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_posit();
    logic [AW-1:0] r;
    r[18:2] = 17'($urandom);
    r[1]    = ($urandom_range(0, 15) == 0);
    r[0]    = ($urandom_range(0, 15) == 0);
    return r;
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_in1[i*AW +: AW] = rand_posit();
      bus.req_in2[i*AW +: AW] = rand_posit();
    end
  endtask

  // One clock: record handshakes and pops just before the edge, then step past it.
  task automatic tick();
    logic [SW-1:0] e;
    #2;
    check("ready_subset_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
    check("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        exp_q[i].push_back(raw_add(bus.req_in1[i*AW +: AW], bus.req_in2[i*AW +: AW]));
        grant_log.push_back(i);
      end
      if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
        pop_cnt[i]++;
        n_checks++;
        assert (exp_q[i].size() != 0) else begin
          n_errors++;
          $error("FAIL rsp_unexpected[%0d]: observed=%0h expected=no response", i, bus.rsp_sum[i*SW +: SW]);
        end
        if (exp_q[i].size() != 0) begin
          e = exp_q[i].pop_front();
          check($sformatf("rsp_sum[%0d]", i), 64'(bus.rsp_sum[i*SW +: SW]), 64'(e));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  int last_grant;
  int cnt [NREQ];
  int pops_before [NREQ];
  logic [AW-1:0] one_p;

  initial begin
    one_p = '0;
    rst = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    bus.req_in1 = '0;
    bus.req_in2 = '0;
    for (int i = 0; i < NREQ; i++) pop_cnt[i] = 0;
    randomize_ops();

    // Reset state, with requests offered during reset
    repeat (3) tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_add_start", 64'(bus.add_start), 64'd0);
    check("rst_add_in1", 64'(bus.add_in1), 64'd0);
    check("rst_add_in2", 64'(bus.add_in2), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    grant_log.delete();

    // Single op: 1.0 + 1.0 from requester 0
    rst = 1'b0;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = '1;
    bus.req_in1[0 +: AW] = one_p;
    bus.req_in2[0 +: AW] = one_p;
    #1;
    check("single_grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = '0;
    check("single_add_start", 64'(bus.add_start), 64'd1);
    check("single_add_in1", 64'(bus.add_in1), 64'(one_p));
    repeat (LAT) tick();
    check("single_rsp_early", 64'(bus.rsp_valid), 64'd0);
    tick();
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("single_rsp_sum", 64'(bus.rsp_sum[0 +: SW]), 64'h1000);
    tick();
    check("single_rsp_popped", 64'(bus.rsp_valid), 64'd0);
    check("single_err", 64'(bus.err), 64'd0);

    // Full contention for 12 cycles
    last_grant = grant_log[$];
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) pops_before[i] = pop_cnt[i];
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      randomize_ops();
      tick();
      check($sformatf("cont_add_start_%0d", k), 64'(bus.add_start), 64'd1);
    end
    bus.req_valid = '0;
    tick();
    check("cont_add_start_end", 64'(bus.add_start), 64'd0);
    check("cont_grant_count", 64'(grant_log.size()), 64'd12);
    for (int j = 0; j < grant_log.size(); j++)
      check($sformatf("cont_grant_%0d", j), 64'(grant_log[j]), 64'((last_grant + 1 + j) % NREQ));
    repeat (20) tick();
    for (int i = 0; i < NREQ; i++)
      check($sformatf("cont_pops_%0d", i), 64'(pop_cnt[i] - pops_before[i]), 64'd3);

    // Backpressure on requester 2
    grant_log.delete();
    bus.req_valid = '1;
    bus.rsp_ready = 4'b1011;
    for (int k = 0; k < 30; k++) begin
      randomize_ops();
      tick();
    end
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    foreach (grant_log[j]) cnt[grant_log[j]]++;
    check("bp_grants_2", 64'(cnt[2]), 64'd4);
    check("bp_others_continue", 64'((cnt[0] > 4) && (cnt[1] > 4) && (cnt[3] > 4)), 64'd1);
    check("bp_ready_2_low", 64'(bus.req_ready[2]), 64'd0);
    check("bp_rsp_valid_2", 64'(bus.rsp_valid[2]), 64'd1);

    // Credit-0 pop: no grant in the pop cycle, grant one cycle later
    bus.req_valid = 4'b0100;
    bus.rsp_ready = '1;
    #1;
    check("credit0_pop_no_grant", 64'(bus.req_ready), 64'd0);
    tick();
    check("credit0_grant_after_pop", 64'(bus.req_ready), 64'b0100);
    tick();
    bus.req_valid = '0;
    repeat (25) tick();
    for (int i = 0; i < NREQ; i++)
      check($sformatf("bp_drained_%0d", i), 64'(exp_q[i].size()), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 100; k++) begin
      bus.req_valid = 4'($urandom);
      bus.rsp_ready = 4'($urandom);
      randomize_ops();
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (30) tick();
    for (int i = 0; i < NREQ; i++)
      check($sformatf("rand_drained_%0d", i), 64'(exp_q[i].size()), 64'd0);
    check("rand_err", 64'(bus.err), 64'd0);

    // Reset with three ops in flight
    grant_log.delete();
    bus.req_valid = 4'b1011;
    randomize_ops();
    repeat (3) tick();
    bus.req_valid = '0;
    check("midrst_issued", 64'(grant_log.size()), 64'd3);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_err", 64'(bus.err), 64'd0);
    bus.req_valid = 4'b0010;
    randomize_ops();
    tick();
    bus.req_valid = '0;
    for (int k = 0; k < LAT; k++) begin
      tick();
      check($sformatf("midrst_quiet_%0d", k), 64'({bus.err, bus.rsp_valid}), 64'd0);
    end
    tick();
    check("midrst_new_rsp", 64'(bus.rsp_valid), 64'b0010);
    tick();
    check("midrst_err_after", 64'(bus.err), 64'd0);
    check("midrst_drained", 64'(exp_q[1].size()), 64'd0);

    // Spurious done with nothing outstanding
    repeat (15) tick();
    check("spur_err_before", 64'(bus.err), 64'd0);
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    check("spur_err_set", 64'(bus.err), 64'd1);
    check("spur_no_write", 64'(bus.rsp_valid), 64'd0);
    repeat (10) tick();
    check("spur_err_sticky", 64'(bus.err), 64'd1);
    check("spur_no_write_late", 64'(bus.rsp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
